// File: rtl/operand_entry_fsm.sv
// Keypad operand/operator entry: assembles two decimal operands and an operator for the ALU.
// Build option KBD_LEADING_ZERO_SUPPRESS_EN: drop leading zeros and accept empty buffer as 0.
module operand_entry_fsm #(
  parameter int NUM_DIGITS = 3,
  parameter int OPW        = 10,
  localparam int CW        = $clog2(NUM_DIGITS + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    code_valid,
  input  logic [3:0]              binary_in,
  input  logic                    enter_in,
  output logic [OPW-1:0]          operand_a,
  output logic [OPW-1:0]          operand_b,
  output logic [1:0]              op_code,
  output logic                    result_valid,
  output logic [4*NUM_DIGITS-1:0] disp_bcd,
  output logic [CW-1:0]           disp_count,
  output logic [1:0]              entry_state
);

  // state   | meaning
  // ENTER_A | collecting first operand, operator key captures it
  // ENTER_B | collecting second operand, enter captures it
  // DONE    | result presented, next digit/backspace starts over

  typedef enum logic [1:0] {
    ENTER_A = 2'b00,
    ENTER_B = 2'b01,
    DONE    = 2'b10
  } state_t;

`ifdef KBD_LEADING_ZERO_SUPPRESS_EN
  localparam bit LZS = 1'b1;
`else
  localparam bit LZS = 1'b0;
`endif

  state_t                  state_q, state_d;
  logic [OPW-1:0]          operand_a_q, operand_a_d;
  logic [OPW-1:0]          operand_b_q, operand_b_d;
  logic [1:0]              op_code_q, op_code_d;
  logic                    result_valid_q, result_valid_d;
  logic [4*NUM_DIGITS-1:0] disp_bcd_q, disp_bcd_d;
  logic [CW-1:0]           disp_count_q, disp_count_d;

  logic [OPW-1:0] conv;
  logic           is_digit, is_op, is_bs;
  logic           buf_empty, buf_full, digit_ok, cap_ok;

  // Horner form of sum(digit_i * 10^i); truncation mod 2^OPW is preserved.
  always_comb begin
    conv = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      conv = OPW'(conv * OPW'(10)) + OPW'(disp_bcd_q[i*4 +: 4]);
    end
  end

  always_comb begin
    is_digit  = (binary_in <= 4'd9);
    is_op     = (binary_in >= 4'hA) && (binary_in <= 4'hD);
    is_bs     = (binary_in == 4'hE);
    buf_empty = (disp_count_q == '0);
    buf_full  = (disp_count_q >= CW'(NUM_DIGITS));
    digit_ok  = !buf_full && !(LZS && buf_empty && (binary_in == 4'd0));
    cap_ok    = !buf_empty || LZS;
  end

  always_comb begin
    state_d        = state_q;
    operand_a_d    = operand_a_q;
    operand_b_d    = operand_b_q;
    op_code_d      = op_code_q;
    result_valid_d = 1'b0;
    disp_bcd_d     = disp_bcd_q;
    disp_count_d   = disp_count_q;

    if (code_valid) begin
      if (enter_in) begin
        if (state_q == ENTER_B && cap_ok) begin
          operand_b_d    = conv;
          result_valid_d = 1'b1;
          disp_bcd_d     = '0;
          disp_count_d   = '0;
          state_d        = DONE;
        end
      end else begin
        unique case (state_q)
          ENTER_A, ENTER_B: begin
            if (is_digit && digit_ok) begin
              disp_bcd_d   = {disp_bcd_q[4*NUM_DIGITS-5:0], binary_in};
              disp_count_d = disp_count_q + CW'(1);
            end else if (is_bs && !buf_empty) begin
              disp_bcd_d   = disp_bcd_q >> 4;
              disp_count_d = disp_count_q - CW'(1);
            end else if (is_bs && state_q == ENTER_B) begin
              state_d = ENTER_A;
            end else if (is_op && state_q == ENTER_A && cap_ok) begin
              operand_a_d  = conv;
              op_code_d    = 2'(binary_in - 4'hA);
              disp_bcd_d   = '0;
              disp_count_d = '0;
              state_d      = ENTER_B;
            end else if (is_op && state_q == ENTER_B && buf_empty) begin
              op_code_d = 2'(binary_in - 4'hA);
            end
          end
          DONE: begin
            // Buffer is already empty here, so a fresh digit lands as the sole digit.
            if (is_digit) begin
              state_d = ENTER_A;
              if (digit_ok) begin
                disp_bcd_d   = {{(4*NUM_DIGITS-4){1'b0}}, binary_in};
                disp_count_d = CW'(1);
              end
            end else if (is_bs) begin
              state_d      = ENTER_A;
              disp_bcd_d   = '0;
              disp_count_d = '0;
            end
          end
          default: state_d = ENTER_A;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ENTER_A;
      operand_a_q    <= '0;
      operand_b_q    <= '0;
      op_code_q      <= 2'b00;
      result_valid_q <= 1'b0;
      disp_bcd_q     <= '0;
      disp_count_q   <= '0;
    end else begin
      state_q        <= state_d;
      operand_a_q    <= operand_a_d;
      operand_b_q    <= operand_b_d;
      op_code_q      <= op_code_d;
      result_valid_q <= result_valid_d;
      disp_bcd_q     <= disp_bcd_d;
      disp_count_q   <= disp_count_d;
    end
  end

  assign operand_a    = operand_a_q;
  assign operand_b    = operand_b_q;
  assign op_code      = op_code_q;
  assign result_valid = result_valid_q;
  assign disp_bcd     = disp_bcd_q;
  assign disp_count   = disp_count_q;
  assign entry_state  = state_q;

endmodule
